// File: rtl/serial_loader.sv
// UART (8N1) host-command loader: 'W' writes a block of bytes to memory, 'G' issues a run request.
// Optional SERIAL_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte to each 'W' command.
module serial_loader #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        run,
  output logic [15:0] run_addr,
  output logic        err
);
  localparam int DIVIDER = CLK_HZ / BAUD;
  localparam int HALF    = DIVIDER / 2;
  localparam int CW      = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  logic [1:0]    sync_reg;
  logic          rx_prev_reg;
  logic          rx_s;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          byte_valid;
  logic          frame_err;

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg     <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= R_IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
    end else begin
      sync_reg     <= {sync_reg[0], rx};
      rx_prev_reg  <= rx_s;
      rx_state_reg <= rx_state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    cnt_next      = cnt_reg + 1'b1;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s) rx_state_next = R_START;
      end
      R_START: begin
        if (cnt_reg == CW'(HALF - 1)) begin
          cnt_next = '0;
          bit_next = '0;
          rx_state_next = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_reg == CW'(DIVIDER - 1)) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) rx_state_next = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_reg == CW'(DIVIDER - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            byte_valid    = 1'b1;
            rx_state_next = R_IDLE;
          end else begin
            frame_err     = 1'b1;
            rx_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // a broken frame may leave the line low; only re-arm once it idles high
        cnt_next = '0;
        if (rx_s) rx_state_next = R_IDLE;
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  // ---------------- command parser ----------------
  typedef enum logic [3:0] {
    IDLE, W_AH, W_AL, W_CNT, W_DATA, W_WRITE, G_AH, G_AL
`ifdef SERIAL_LOADER_CHECKSUM_EN
    , W_CSUM
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] addr_next;
  logic [7:0]  data_next;
  logic        we_reg, we_next;
  logic [7:0]  remain_reg, remain_next;
  logic [15:0] run_addr_next;
  logic        run_next;
  logic        err_next;
  logic        last_write;
`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [7:0]  sum_reg, sum_next;
`endif

  // an arriving byte during a pending write cancels the handshake in that same cycle
  assign mem_we = we_reg & ~byte_valid;
  assign busy   = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      we_reg     <= 1'b0;
      remain_reg <= '0;
      run_addr   <= '0;
      run        <= 1'b0;
      err        <= 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      mem_addr   <= addr_next;
      mem_data   <= data_next;
      we_reg     <= we_next;
      remain_reg <= remain_next;
      run_addr   <= run_addr_next;
      run        <= run_next;
      err        <= err_next;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_reg    <= sum_next;
`endif
    end
  end

  // a stored count of 0 naturally stands for 256 bytes
  assign last_write = (remain_reg == 8'd1);

  always_comb begin
    state_next    = state_reg;
    addr_next     = mem_addr;
    data_next     = mem_data;
    we_next       = we_reg;
    remain_next   = remain_reg;
    run_addr_next = run_addr;
    run_next      = 1'b0;
    err_next      = err;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    sum_next      = sum_reg;
`endif
    case (state_reg)
      IDLE: if (byte_valid) begin
        if (shift_reg == 8'h57) begin
          state_next = W_AH;
          err_next   = 1'b0;
        end else if (shift_reg == 8'h47) begin
          state_next = G_AH;
          err_next   = 1'b0;
        end
      end
      W_AH: if (byte_valid) begin
        addr_next[15:8] = shift_reg;
        state_next      = W_AL;
      end
      W_AL: if (byte_valid) begin
        addr_next[7:0] = shift_reg;
        state_next     = W_CNT;
      end
      W_CNT: if (byte_valid) begin
        remain_next = shift_reg;
        state_next  = W_DATA;
      end
      W_DATA: if (byte_valid) begin
        data_next  = shift_reg;
        we_next    = 1'b1;
        state_next = W_WRITE;
      end
      W_WRITE: begin
        if (byte_valid) begin
          err_next   = 1'b1;
          we_next    = 1'b0;
          state_next = IDLE;
        end else if (mem_ready) begin
          we_next     = 1'b0;
          addr_next   = mem_addr + 16'd1;
          remain_next = remain_reg - 8'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
          state_next  = last_write ? W_CSUM : W_DATA;
`else
          state_next  = last_write ? IDLE : W_DATA;
`endif
        end
      end
      G_AH: if (byte_valid) begin
        run_addr_next[15:8] = shift_reg;
        state_next          = G_AL;
      end
      G_AL: if (byte_valid) begin
        run_addr_next[7:0] = shift_reg;
        run_next           = 1'b1;
        state_next         = IDLE;
      end
`ifdef SERIAL_LOADER_CHECKSUM_EN
      W_CSUM: if (byte_valid) begin
        if (8'(sum_reg + shift_reg) != 8'h00) err_next = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

`ifdef SERIAL_LOADER_CHECKSUM_EN
    if (byte_valid) begin
      if (state_reg == IDLE)
        sum_next = 8'h00;
      else if (state_reg inside {W_AH, W_AL, W_CNT, W_DATA})
        sum_next = sum_reg + shift_reg;
    end
`endif

    if (frame_err) begin
      state_next = IDLE;
      we_next    = 1'b0;
      err_next   = 1'b1;
      run_next   = 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: write, address wrap, run, overrun, framing error, async reset
// and (when SERIAL_LOADER_CHECKSUM_EN is defined) checksum accept/reject.
module tb_serial_loader;
  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        run;
  logic [15:0] run_addr;
  logic        err;

  int checks = 0;
  int failures = 0;

  serial_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .run(run), .run_addr(run_addr), .err(err)
  );

  always #5 clk = ~clk;

  // bus monitor: cumulative counters, tests look at deltas
  logic [15:0] wr_addr [0:31];
  logic [7:0]  wr_data [0:31];
  int wr_n = 0;
  int we_cycles = 0;
  int run_cycles = 0;
  logic [15:0] run_seen = 16'h0;

  always @(posedge clk) begin
    #1;
    if (mem_we) we_cycles <= we_cycles + 1;
    if (mem_we && mem_ready) begin
      wr_addr[wr_n % 32] <= mem_addr;
      wr_data[wr_n % 32] <= mem_data;
      wr_n <= wr_n + 1;
    end
    if (run) begin
      run_cycles <= run_cycles + 1;
      run_seen   <= run_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    rx = 1'b1;
    tick(DIV);
    $display("tx byte=%h stop=%0b busy=%0b we=%0b err=%0b", b, stop, busy, mem_we, err);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(4);
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_data !== 8'h00) begin failures++; $display("FAIL reset_mem_data got=%h exp=00", mem_data); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if (run_addr !== 16'h0000) begin failures++; $display("FAIL reset_run_addr got=%h exp=0000", run_addr); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_write_basic;
    int w0, we0;
    mem_ready = 1'b1;
    w0 = wr_n; we0 = we_cycles;
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    tick(4);
    checks++; if (wr_n - w0 !== 2) begin failures++; $display("FAIL basic_write_count got=%0d exp=2", wr_n - w0); end
    checks++; if (wr_addr[w0 % 32] !== 16'h1234 || wr_data[w0 % 32] !== 8'hAA) begin failures++;
      $display("FAIL basic_write0 got=%h<-%h exp=1234<-aa", wr_addr[w0 % 32], wr_data[w0 % 32]); end
    checks++; if (wr_addr[(w0 + 1) % 32] !== 16'h1235 || wr_data[(w0 + 1) % 32] !== 8'h55) begin failures++;
      $display("FAIL basic_write1 got=%h<-%h exp=1235<-55", wr_addr[(w0 + 1) % 32], wr_data[(w0 + 1) % 32]); end
    checks++; if (we_cycles - we0 !== 2) begin failures++; $display("FAIL basic_we_cycles got=%0d exp=2", we_cycles - we0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_wrap;
    int w0;
    w0 = wr_n;
    send_byte(8'h57, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    tick(4);
    checks++; if (wr_n - w0 !== 2) begin failures++; $display("FAIL wrap_write_count got=%0d exp=2", wr_n - w0); end
    checks++; if (wr_addr[w0 % 32] !== 16'hFFFF || wr_data[w0 % 32] !== 8'h01) begin failures++;
      $display("FAIL wrap_write0 got=%h<-%h exp=ffff<-01", wr_addr[w0 % 32], wr_data[w0 % 32]); end
    checks++; if (wr_addr[(w0 + 1) % 32] !== 16'h0000 || wr_data[(w0 + 1) % 32] !== 8'h02) begin failures++;
      $display("FAIL wrap_write1 got=%h<-%h exp=0000<-02", wr_addr[(w0 + 1) % 32], wr_data[(w0 + 1) % 32]); end
  endtask

  task automatic test_run;
    int r0, we0;
    r0 = run_cycles; we0 = we_cycles;
    send_byte(8'h47, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
    tick(4);
    checks++; if (run_cycles - r0 !== 1) begin failures++; $display("FAIL run_pulse_cycles got=%0d exp=1", run_cycles - r0); end
    checks++; if (run_seen !== 16'hF800) begin failures++; $display("FAIL run_addr_at_pulse got=%h exp=f800", run_seen); end
    checks++; if (run_addr !== 16'hF800) begin failures++; $display("FAIL run_addr_hold got=%h exp=f800", run_addr); end
    checks++; if (we_cycles - we0 !== 0) begin failures++; $display("FAIL run_no_we got=%0d exp=0", we_cycles - we0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overrun;
    int w0;
    mem_ready = 1'b0;
    w0 = wr_n;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL overrun_pending_we got=%b exp=1", mem_we); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overrun_pending_busy got=%b exp=1", busy); end
    send_byte(8'h22, 1'b1);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL overrun_err got=%b exp=1", err); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL overrun_we got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_busy got=%b exp=0", busy); end
    checks++; if (wr_n - w0 !== 0) begin failures++; $display("FAIL overrun_writes got=%0d exp=0", wr_n - w0); end
    mem_ready = 1'b1;
  endtask

  task automatic test_framing;
    int r0;
    // first clear err with a harmless run command
    send_byte(8'h47, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h57, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL frame_err_set got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_byte_discarded busy got=%b exp=0", busy); end
    r0 = run_cycles;
    send_byte(8'h47, 1'b1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL frame_err_cleared got=%b exp=0", err); end
    send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    tick(2);
    checks++; if (run_cycles - r0 !== 1) begin failures++; $display("FAIL frame_run_pulse got=%0d exp=1", run_cycles - r0); end
    checks++; if (run_seen !== 16'h0010) begin failures++; $display("FAIL frame_run_addr got=%h exp=0010", run_seen); end
  endtask

  task automatic test_reset_mid_write;
    mem_ready = 1'b0;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h33, 1'b1);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL midreset_pending_we got=%b exp=1", mem_we); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL midreset_async_we got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    tick(2);
    reset = 1'b0;
    mem_ready = 1'b1;
    tick(4);
    $display("reset mid-write done we=%0b busy=%0b", mem_we, busy);
  endtask

`ifdef SERIAL_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int w0;
    // 00+00+01+05 = 06, so 0xFA brings the total to zero and 0xFB does not
    w0 = wr_n;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hFA, 1'b1);
    tick(2);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL csum_good_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL csum_good_busy got=%b exp=0", busy); end
    checks++; if (wr_n - w0 !== 1 || wr_addr[w0 % 32] !== 16'h0000 || wr_data[w0 % 32] !== 8'h05) begin failures++;
      $display("FAIL csum_good_write got n=%0d %h<-%h exp n=1 0000<-05", wr_n - w0, wr_addr[w0 % 32], wr_data[w0 % 32]); end
    w0 = wr_n;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hFB, 1'b1);
    tick(2);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL csum_bad_err got=%b exp=1", err); end
    checks++; if (wr_n - w0 !== 1 || wr_addr[w0 % 32] !== 16'h0000) begin failures++;
      $display("FAIL csum_bad_write_kept got n=%0d addr=%h exp n=1 addr=0000", wr_n - w0, wr_addr[w0 % 32]); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_basic;
    test_wrap;
    test_run;
    test_overrun;
    test_framing;
    test_reset_mid_write;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
